// File: rtl/mips_bus_arbiter.sv
// Purpose: shares one Avalon-MM master port between the instruction-fetch and data load/store requesters.
// Latency: a request sampled at edge k drives read/write from k+1; a zero-wait slave gives done in cycle k+2, plus one per wait cycle.
// Backpressure: Avalon waitrequest stretches the BUS phase; requesters hold req and its fields until their done pulse.
module mips_bus_arbiter #(
  parameter int TIMEOUT = 0,   // max consecutive waitrequest-high bus cycles; 0 disables the abort
  parameter int CW      = 16   // timeout counter width
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port (read-only)
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  // data load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  // status
  output logic        err,
  output logic        busy,
  // Avalon-MM master
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } port_t;

  // The abort fires on the last allowed waitrequest-high cycle, i.e. when the
  // counter (cleared on BUS entry) has already counted TIMEOUT-1 stalls.
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state, state_nxt;
  port_t         last_grant, last_grant_nxt;
  port_t         owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [31:0]   address_nxt;
  logic          read_nxt;
  logic          write_nxt;
  logic [31:0]   writedata_nxt;
  logic [3:0]    byteenable_nxt;
  logic [31:0]   i_rdata_nxt;
  logic [31:0]   d_rdata_nxt;
  logic          i_done_nxt;
  logic          d_done_nxt;
  logic          err_nxt;
  logic          busy_nxt;

  // On a tie the port that did not win last time is served; a lone request always wins.
  logic          grant_data;
  assign grant_data = d_req && (!i_req || (last_grant == INSTR));

  // Next-state and next-output logic; every bus-facing output is registered.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    cnt_nxt        = cnt;
    address_nxt    = address;
    read_nxt       = read;
    write_nxt      = write;
    writedata_nxt  = writedata;
    byteenable_nxt = byteenable;
    i_rdata_nxt    = i_rdata;
    d_rdata_nxt    = d_rdata;
    i_done_nxt     = 1'b0;
    d_done_nxt     = 1'b0;
    err_nxt        = 1'b0;

    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_nxt = BUS;
          cnt_nxt   = '0;
          if (grant_data) begin
            owner_nxt      = DATA;
            last_grant_nxt = DATA;
            address_nxt    = {d_addr[31:2], 2'b00};
            byteenable_nxt = d_be;
            writedata_nxt  = d_wdata;
            write_nxt      = d_we;
            read_nxt       = ~d_we;
          end else begin
            owner_nxt      = INSTR;
            last_grant_nxt = INSTR;
            address_nxt    = {i_addr[31:2], 2'b00};
            byteenable_nxt = 4'b1111;
            write_nxt      = 1'b0;
            read_nxt       = 1'b1;
          end
        end
      end

      BUS: begin
        if (!waitrequest) begin
          // Slave accepted: readdata is only valid in this cycle, so grab it now.
          if (read) begin
            if (owner == DATA) d_rdata_nxt = readdata;
            else               i_rdata_nxt = readdata;
          end
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          state_nxt = DONE;
          if (owner == DATA) d_done_nxt = 1'b1;
          else               i_done_nxt = 1'b1;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          // Stuck slave: give up, report the abort and hand back a zero word.
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
          if (owner == DATA) begin
            d_rdata_nxt = '0;
            d_done_nxt  = 1'b1;
          end else begin
            i_rdata_nxt = '0;
            i_done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DONE: begin
        // Completion cycle only; arbitration resumes from IDLE so the
        // requester has this edge to drop its req.
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers with synchronous reset; reset mid-transfer
  // drops read/write immediately and suppresses the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= INSTR;
      owner      <= INSTR;
      cnt        <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
      address    <= address_nxt;
      read       <= read_nxt;
      write      <= write_nxt;
      writedata  <= writedata_nxt;
      byteenable <= byteenable_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      i_done     <= i_done_nxt;
      d_done     <= d_done_nxt;
      err        <= err_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: table of single transactions plus contention,
// timeout, mid-transfer reset and held-request sequences.
// Expected transactions are queued when driven and compared on each done pulse.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;
  logic        busy;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  mips_bus_arbiter #(.TIMEOUT(8), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .err(err), .busy(busy),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Slave model: waitrequest high for wait_cfg cycles of each transfer, or forever when stuck.
  int bus_cnt = 0;
  int wait_cfg = 0;
  logic stuck = 1'b0;
  always @(posedge clk) bus_cnt <= (read || write) ? bus_cnt + 1 : 0;
  assign waitrequest = stuck || (bus_cnt < wait_cfg);

  typedef struct {
    bit          port;      // 0 = fetch, 1 = data
    bit          we;
    logic [31:0] addr;      // word-aligned address expected on the bus
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          err;
    int          bus;       // cycles read/write is high
  } exp_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    bit          stuck;
    logic [31:0] rin;
    int          lat;       // negedges from req assertion to visible done
    exp_t        exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;
  exp_t popped;
  int   bus_cyc = 0;
  int   i_done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk_exp(bit port, bit we, logic [31:0] addr, logic [31:0] wdata,
                                  logic [3:0] be, logic [31:0] rdata, bit chk_rd, bit e, int bus);
    exp_t x;
    x.port = port; x.we = we; x.addr = addr; x.wdata = wdata; x.be = be;
    x.rdata = rdata; x.chk_rdata = chk_rd; x.err = e; x.bus = bus;
    return x;
  endfunction

  function automatic vec_t mk_vec(bit port, bit we, logic [31:0] addr, logic [31:0] wdata,
                                  logic [3:0] be, int waits, bit stk, logic [31:0] rin, int lat,
                                  exp_t x);
    vec_t v;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.waits = waits; v.stuck = stk; v.rin = rin; v.lat = lat; v.exp = x;
    return v;
  endfunction

  // Bus and completion monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      bus_cyc = 0;
    end else begin
      if (i_done) i_done_cnt++;
      if (i_done && d_done) chk("two_done", 1, 0);
      if (read || write) begin
        bus_cyc++;
        if (q.size() > 0) begin
          mon_e = q[0];
          chk("bus_addr", address, mon_e.addr);
          chk("bus_ctl", {byteenable, read, write}, {mon_e.be, ~mon_e.we, mon_e.we});
          if (write) chk("bus_wdata", writedata, mon_e.wdata);
        end
      end
      if (i_done || d_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", {i_done, d_done}, 2'b00);
        end else begin
          popped = q.pop_front();
          chk("done_port", {i_done, d_done}, popped.port ? 2'b01 : 2'b10);
          chk("done_err", err, popped.err);
          chk("bus_cycles", bus_cyc, popped.bus);
          chk("done_busy_rw", {busy, read, write}, 3'b100);
          if (popped.chk_rdata)
            chk("rdata", popped.port ? d_rdata : i_rdata, popped.rdata);
        end
        bus_cyc = 0;
      end else begin
        chk("err_idle", err, 0);
      end
    end
  end

  task automatic wait_done(output int n, output bit seen);
    n = 0;
    seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (i_done || d_done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    bit seen;
    wait_cfg = v.waits;
    stuck    = v.stuck;
    readdata = v.rin;
    if (v.port) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      i_req = 1; i_addr = v.addr;
    end
    q.push_back(v.exp);
    wait_done(n, seen);
    if (seen) chk({name, "_latency"}, n, v.lat);
    i_req = 0;
    d_req = 0;
    @(negedge clk);
    chk({name, "_idle"}, {busy, read, write, i_done, d_done}, 5'b0);
    stuck = 0;
  endtask

  vec_t tbl[6];

  initial begin
    int n;
    bit seen;
    int dones;
    bit re_i, re_d;

    tbl[0] = mk_vec(0, 0, 32'hBFC00000, 32'h0, 4'h0, 0, 0, 32'h24020005, 2,
                    mk_exp(0, 0, 32'hBFC00000, 32'h0, 4'hF, 32'h24020005, 1, 0, 1));
    tbl[1] = mk_vec(1, 1, 32'h00001006, 32'hDEADBEEF, 4'hC, 3, 0, 32'h55555555, 5,
                    mk_exp(1, 1, 32'h00001004, 32'hDEADBEEF, 4'hC, 32'h0, 0, 0, 4));
    tbl[2] = mk_vec(1, 0, 32'h0000200B, 32'h0, 4'h3, 1, 0, 32'h12345678, 3,
                    mk_exp(1, 0, 32'h00002008, 32'h0, 4'h3, 32'h12345678, 1, 0, 2));
    tbl[3] = mk_vec(0, 0, 32'h00400003, 32'h0, 4'h0, 2, 0, 32'h0BADF00D, 4,
                    mk_exp(0, 0, 32'h00400000, 32'h0, 4'hF, 32'h0BADF00D, 1, 0, 3));
    tbl[4] = mk_vec(0, 0, 32'h80000010, 32'h0, 4'h0, 0, 1, 32'hFFFFFFFF, 9,
                    mk_exp(0, 0, 32'h80000010, 32'h0, 4'hF, 32'h0, 1, 1, 8));
    tbl[5] = mk_vec(1, 0, 32'h00000004, 32'h0, 4'hF, 0, 0, 32'hA5A5A5A5, 2,
                    mk_exp(1, 0, 32'h00000004, 32'h0, 4'hF, 32'hA5A5A5A5, 1, 0, 1));

    reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_be = 0; readdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_bus", {address, writedata, byteenable, read, write}, 70'h0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    chk("rst_status", {i_done, d_done, err, busy}, 4'h0);
    reset = 0;
    @(negedge clk);

    // Table of single transactions.
    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Contention straight out of reset: DATA, INSTR, DATA, INSTR.
    reset = 1;
    q.delete();
    i_req = 1; i_addr = 32'h00000100;
    d_req = 1; d_we = 0; d_addr = 32'h00002000; d_be = 4'hF;
    readdata = 32'hCAFE0001; wait_cfg = 0;
    for (int i = 0; i < 2; i++) begin
      q.push_back(mk_exp(1, 0, 32'h00002000, 32'h0, 4'hF, 32'hCAFE0001, 1, 0, 1));
      q.push_back(mk_exp(0, 0, 32'h00000100, 32'h0, 4'hF, 32'hCAFE0001, 1, 0, 1));
    end
    repeat (2) @(negedge clk);
    reset = 0;
    dones = 0; re_i = 0; re_d = 0;
    for (int c = 0; c < 60 && dones < 4; c++) begin
      @(negedge clk);
      if (re_i) begin i_req = 1; re_i = 0; end
      if (re_d) begin d_req = 1; re_d = 0; end
      if (i_done) begin i_req = 0; re_i = 1; dones++; end
      if (d_done) begin d_req = 0; re_d = 1; dones++; end
    end
    i_req = 0; d_req = 0;
    chk("contention_dones", dones, 4);
    repeat (4) @(negedge clk);
    chk("contention_drain", q.size(), 0);

    // Reset while a stalled fetch is on the bus.
    q.delete();
    stuck = 1;
    i_req = 1; i_addr = 32'h00000200;
    q.push_back(mk_exp(0, 0, 32'h00000200, 32'h0, 4'hF, 32'h0, 0, 0, 0));
    repeat (4) @(negedge clk);
    chk("midrst_before", {read, busy}, 2'b11);
    reset = 1; i_req = 0;
    @(negedge clk);
    chk("midrst_after", {read, write, busy, i_done, d_done, err}, 6'b0);
    @(negedge clk);
    chk("midrst_nodone", {i_done, d_done}, 2'b00);
    q.delete();
    reset = 0; stuck = 0;
    @(negedge clk);
    run_vec(mk_vec(0, 0, 32'h00000300, 32'h0, 4'h0, 1, 0, 32'h13579BDF, 3,
                   mk_exp(0, 0, 32'h00000300, 32'h0, 4'hF, 32'h13579BDF, 1, 0, 2)), "post_rst");

    // Fetch req held through the done cycle and the following IDLE cycle.
    i_done_cnt = 0;
    wait_cfg = 0;
    readdata = 32'h11112222;
    q.push_back(mk_exp(0, 0, 32'h00000040, 32'h0, 4'hF, 32'h11112222, 1, 0, 1));
    q.push_back(mk_exp(0, 0, 32'h00000040, 32'h0, 4'hF, 32'h11112222, 1, 0, 1));
    i_req = 1; i_addr = 32'h00000040;
    wait_done(n, seen);
    repeat (2) @(negedge clk);
    i_req = 0;
    repeat (12) @(negedge clk);
    chk("held_req_fetches", i_done_cnt, 2);
    chk("held_req_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
